// File: rtl/machine_reset_seq.sv
// rtl/machine_reset_seq.sv - reset sequencer: synchronised request, timed pulse, delayed copy, hold-off
// Power-on behaves like a pulse in progress; retriggers arriving during hold-off are folded into one.
module machine_reset_seq #(
   parameter int SYNC_STAGES    = 2,
   parameter int PULSE_CYCLES   = 16,
   parameter int RELEASE_DELAY  = 4,
   parameter int HOLDOFF_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trigger_in,
   input  logic       level_mode,
   output logic       reset_out,
   output logic       reset_out_dly,
   output logic       busy,
   output logic [7:0] pulse_count
);

   localparam int MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int DW = (RELEASE_DELAY > 0) ? RELEASE_DELAY : 1;
   localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ASSERT, HOLD, HOLDOFF} state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   trig_q, trig_d;
   logic                   trig_s, trig_edge;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   pending_q, pending_d;
   logic                   reset_out_q, reset_out_d;
   logic                   busy_q, busy_d;
   logic [7:0]             count_q, count_d;
   logic [DW-1:0]          dly_q, dly_d;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], trigger_in};
      trig_s    = sync_q[SYNC_STAGES-1];
      trig_d    = trig_s;
      trig_edge = trig_s & ~trig_q;

      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            pending_d = 1'b0;
            if (trig_edge) begin
               state_d = ASSERT;
               cnt_d   = PULSE_LOAD;
               count_d = count_q + 8'd1;
            end
         end
         ASSERT: begin
            pending_d = 1'b0;
            if (cnt_q == '0) begin
               if (level_mode && trig_s) begin
                  state_d = HOLD;
               end else begin
                  state_d = HOLDOFF;
                  cnt_d   = HOLDOFF_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            pending_d = 1'b0;
            if (!trig_s) begin
               state_d = HOLDOFF;
               cnt_d   = HOLDOFF_LOAD;
            end
         end
         HOLDOFF: begin
            // An edge on the final quiet cycle still counts as a retrigger.
            if (cnt_q == '0) begin
               pending_d = 1'b0;
               if (pending_q || trig_edge) begin
                  state_d = ASSERT;
                  cnt_d   = PULSE_LOAD;
                  count_d = count_q + 8'd1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (trig_edge) pending_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      reset_out_d = (state_d == ASSERT) || (state_d == HOLD);
      busy_d      = (state_d != IDLE);
      dly_d       = DW'({dly_q, reset_out_q});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= '0;
         trig_q      <= 1'b0;
         state_q     <= ASSERT;
         cnt_q       <= PULSE_LOAD;
         pending_q   <= 1'b0;
         reset_out_q <= 1'b1;
         busy_q      <= 1'b1;
         count_q     <= 8'd0;
         dly_q       <= '1;
      end else begin
         sync_q      <= sync_d;
         trig_q      <= trig_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         reset_out_q <= reset_out_d;
         busy_q      <= busy_d;
         count_q     <= count_d;
         dly_q       <= dly_d;
      end
   end

   assign reset_out     = reset_out_q;
   assign reset_out_dly = (RELEASE_DELAY == 0) ? reset_out_q : dly_q[DW-1];
   assign busy          = busy_q;
   assign pulse_count   = count_q;

endmodule

// File: tb/tb_machine_reset_seq.sv
// tb/tb_machine_reset_seq.sv - self-checking bench for machine_reset_seq
module tb_machine_reset_seq;

   logic       clk = 1'b0;
   logic       reset_n, trigger_in, level_mode;
   logic       reset_out, reset_out_dly, busy;
   logic [7:0] pulse_count;
   logic       trig_w, lvl_w;
   logic       ro_w, rod_w, busy_w;
   logic [7:0] cnt_w;

   always #5 clk = ~clk;

   machine_reset_seq dut (
      .clk(clk), .reset_n(reset_n), .trigger_in(trigger_in), .level_mode(level_mode),
      .reset_out(reset_out), .reset_out_dly(reset_out_dly), .busy(busy), .pulse_count(pulse_count)
   );

   // Short hold-off instance so 256 pulses fit in a reasonable run.
   machine_reset_seq #(.HOLDOFF_CYCLES(4)) dut_w (
      .clk(clk), .reset_n(reset_n), .trigger_in(trig_w), .level_mode(lvl_w),
      .reset_out(ro_w), .reset_out_dly(rod_w), .busy(busy_w), .pulse_count(cnt_w)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int width;
      int start;
      int count;
   } exp_t;

   exp_t sb[$];
   bit   mon_en = 1'b0;
   logic prev_ro = 1'b1;
   int   rise_cyc = 0;
   int   model_count = 0;

   always begin
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (reset_out && !prev_ro) begin
            rise_cyc = cyc;
            check("pulse_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) check("pulse_start", cyc, sb[0].start);
         end
         if (!reset_out && prev_ro && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_width", cyc - rise_cyc, e.width);
            check("pulse_count", int'(pulse_count), e.count);
         end
      end
      prev_ro = reset_out;
   end

   task automatic wait_for(input int sel, input logic val, input int max_cyc, output int at);
      logic s;
      at = -1;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         #1;
         case (sel)
            0:       s = reset_out;
            1:       s = reset_out_dly;
            2:       s = busy;
            3:       s = ro_w;
            default: s = busy_w;
         endcase
         if (s === val) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic send(input logic lvl, input int len, input int width);
      exp_t e;
      @(negedge clk);
      level_mode  = lvl;
      model_count = (model_count + 1) % 256;
      e.width = width;
      e.start = cyc + 3;
      e.count = model_count;
      sb.push_back(e);
      trigger_in = 1'b1;
      repeat (len) @(negedge clk);
      trigger_in = 1'b0;
   endtask

   typedef struct {
      logic lvl;
      int   len;
      int   width;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int at, rel, f, r;
      exp_t e;

      vecs[0] = '{1'b0, 3, 16};
      vecs[1] = '{1'b0, 1, 16};
      vecs[2] = '{1'b0, 40, 16};
      vecs[3] = '{1'b1, 100, 100};
      vecs[4] = '{1'b1, 5, 16};
      vecs[5] = '{1'b1, 16, 16};
      vecs[6] = '{1'b1, 17, 17};

      reset_n = 1'b0; trigger_in = 1'b0; level_mode = 1'b0; trig_w = 1'b0; lvl_w = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_reset_out", reset_out, 1);
      check("rst_reset_out_dly", reset_out_dly, 1);
      check("rst_busy", busy, 1);
      check("rst_pulse_count", pulse_count, 0);

      // Power-on pulse
      @(negedge clk);
      reset_n = 1'b1;
      rel = cyc;
      wait_for(0, 1'b0, 100, at);
      check("por_fall", at, rel + 16);
      wait_for(1, 1'b0, 20, at);
      check("por_dly_fall", at, rel + 20);
      wait_for(2, 1'b0, 1100, at);
      check("por_busy_fall", at, rel + 1040);
      check("por_pulse_count", pulse_count, 0);

      prev_ro = reset_out;
      mon_en  = 1'b1;
      foreach (vecs[i]) begin
         send(vecs[i].lvl, vecs[i].len, vecs[i].width);
         wait_for(2, 1'b1, 20, at);
         wait_for(2, 1'b0, 2000, at);
         check("vec_idle", int'(at >= 0), 1);
         check("vec_sb_drained", sb.size(), 0);
      end

      // Two edges during hold-off fold into one retrigger
      send(1'b0, 2, 16);
      wait_for(0, 1'b1, 50, at);
      wait_for(0, 1'b0, 50, f);
      while (cyc < f + 10) @(negedge clk);
      trigger_in = 1'b1;
      @(negedge clk);
      trigger_in = 1'b0;
      while (cyc < f + 500) @(negedge clk);
      model_count = (model_count + 1) % 256;
      e.width = 16; e.start = f + 1024; e.count = model_count;
      sb.push_back(e);
      trigger_in = 1'b1;
      repeat (2) @(negedge clk);
      trigger_in = 1'b0;
      wait_for(2, 1'b0, 3000, at);
      check("retrig_idle", at, f + 2064);
      check("retrig_count", pulse_count, model_count);
      check("retrig_sb_drained", sb.size(), 0);

      // Reset mid-pulse, then reset during hold-off with a pending retrigger
      mon_en = 1'b0;
      sb.delete();
      @(negedge clk);
      trigger_in = 1'b1;
      @(negedge clk);
      trigger_in = 1'b0;
      wait_for(0, 1'b1, 20, r);
      while (cyc < r + 7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_reset_out", reset_out, 1);
      check("midrst_dly", reset_out_dly, 1);
      check("midrst_busy", busy, 1);
      check("midrst_count", pulse_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      rel = cyc;
      wait_for(0, 1'b0, 40, at);
      check("midrst_fall", at, rel + 16);
      while (cyc < rel + 100) @(negedge clk);
      trigger_in = 1'b1;
      repeat (2) @(negedge clk);
      trigger_in = 1'b0;
      while (cyc < rel + 200) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      rel = cyc;
      wait_for(0, 1'b0, 40, at);
      check("pendrst_fall", at, rel + 16);
      wait_for(2, 1'b0, 1100, at);
      check("pendrst_busy_fall", at, rel + 1040);
      wait_for(0, 1'b1, 40, at);
      check("pendrst_no_retrigger", at, -1);
      check("pendrst_count", pulse_count, 0);

      // Counter wrap on the short hold-off instance
      wait_for(4, 1'b0, 100, at);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         trig_w = 1'b1;
         @(negedge clk);
         trig_w = 1'b0;
         wait_for(3, 1'b1, 20, r);
         wait_for(3, 1'b0, 40, f);
         check("wrap_width", f - r, 16);
         check("wrap_count", int'(cnt_w), (i + 1) % 256);
         wait_for(4, 1'b0, 20, at);
      end
      check("wrap_final_zero", cnt_w, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
